// File: rtl/mic_trigger_capture_if.sv
// Sample-buffer write port of the trigger/capture stage.
// The master drives write strobes, the display buffer is the slave.
interface mic_trigger_capture_if #(
    parameter int w_y    = 9,
    parameter int w_addr = 9
);
    logic                     wr_en;
    logic [w_addr-1:0]        wr_addr;
    logic signed [w_y-1:0]    wr_data;
    logic                     frame_done;

    modport master (output wr_en, wr_addr, wr_data, frame_done);
    modport slave  (input  wr_en, wr_addr, wr_data, frame_done);
endinterface

// File: rtl/mic_trigger_capture.sv
// Schmitt-triggered frame capture of the microphone stream, with period measurement.
// Define MIC_TRIGGER_CAPTURE_AUTO_EN to auto-trigger after timeout_cycles idle clocks in ARM.
module mic_trigger_capture #(
    parameter int                   w_y            = 9,
    parameter int                   n_samples      = 320,
    parameter int                   w_addr         = $clog2(n_samples),
    parameter int                   mic_shift      = 9,
    parameter logic signed [23:0]   hyst           = 24'sd4096,
    parameter int                   holdoff_cycles = 1024,
    parameter int                   timeout_cycles = 2**20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [23:0]      mic,
    input  logic [3:0]              decim_log2,
    input  logic                    freeze,
    mic_trigger_capture_if.master   wr,
    output logic [19:0]             period,
    output logic                    period_valid,
    output logic                    auto_trig
);

    localparam logic signed [23:0] hyst_neg  = -hyst;
    localparam logic signed [23:0] y_max     = (24'sd1 <<< (w_y - 1)) - 24'sd1;
    localparam logic signed [23:0] y_min     = -(24'sd1 <<< (w_y - 1));
    localparam logic [w_addr-1:0]  idx_last  = w_addr'(n_samples - 1);
    localparam int                 w_hold    = $clog2(holdoff_cycles + 1);
    localparam logic [w_hold-1:0]  hold_last = w_hold'(holdoff_cycles - 1);

    typedef enum logic [1:0] {
        ARM,
        CAPTURE,
        HOLDOFF
    } state_t;

    state_t                state;
    logic                  level;
    logic                  rise;
    logic                  seen_rise;
    logic [19:0]           cnt;
    logic [3:0]            d_lat;
    logic [14:0]           div;
    logic [14:0]           div_mask;
    logic [w_addr-1:0]     idx;
    logic [w_hold-1:0]     hold;
    logic signed [23:0]    shifted;
    logic signed [w_y-1:0] scaled;
    logic                  trig_rise;
    logic                  trig_auto;

    // Schmitt detector: rise is a registered single-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= !level && (mic > hyst);
            if (!level && (mic > hyst))
                level <= 1'b1;
            else if (level && (mic < hyst_neg))
                level <= 1'b0;
        end
    end

    // The first rise after reset only restarts the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            seen_rise    <= 1'b0;
        end else begin
            period_valid <= rise && seen_rise;
            if (rise) begin
                if (seen_rise)
                    period <= cnt;
                cnt       <= 20'd1;
                seen_rise <= 1'b1;
            end else if (cnt != '1) begin
                cnt <= cnt + 20'd1;
            end
        end
    end

    always_comb begin
        shifted = mic >>> mic_shift;
        if (shifted > y_max)
            scaled = y_max[w_y-1:0];
        else if (shifted < y_min)
            scaled = y_min[w_y-1:0];
        else
            scaled = shifted[w_y-1:0];
    end

    assign div_mask  = 15'((16'd1 << d_lat) - 16'd1);
    assign trig_rise = rise && !freeze;

`ifdef MIC_TRIGGER_CAPTURE_AUTO_EN
    localparam int                w_idle    = $clog2(timeout_cycles + 1);
    localparam logic [w_idle-1:0] idle_last = w_idle'(timeout_cycles - 1);

    logic [w_idle-1:0] idle;
    logic              auto_r;

    assign trig_auto = !freeze && !rise && (idle == idle_last);
    assign auto_trig = auto_r;
`else
    // Timeout only matters for the auto-trigger build
    localparam int unused_timeout = timeout_cycles;

    assign trig_auto = 1'b0;
    assign auto_trig = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ARM;
            d_lat         <= '0;
            div           <= '0;
            idx           <= '0;
            hold          <= '0;
            wr.wr_en      <= 1'b0;
            wr.wr_addr    <= '0;
            wr.wr_data    <= '0;
            wr.frame_done <= 1'b0;
`ifdef MIC_TRIGGER_CAPTURE_AUTO_EN
            idle          <= '0;
            auto_r        <= 1'b0;
`endif
        end else begin
            wr.wr_en      <= 1'b0;
            wr.frame_done <= 1'b0;
`ifdef MIC_TRIGGER_CAPTURE_AUTO_EN
            if ((state != ARM) || rise)
                idle <= '0;
            else if (!freeze)
                idle <= idle + 1'b1;
`endif
            case (state)
                ARM: begin
                    if (trig_rise || trig_auto) begin
                        state <= CAPTURE;
                        d_lat <= decim_log2;
                        div   <= '0;
                        idx   <= '0;
`ifdef MIC_TRIGGER_CAPTURE_AUTO_EN
                        auto_r <= trig_auto;
`endif
                    end
                end
                CAPTURE: begin
                    div <= (div == div_mask) ? '0 : div + 15'd1;
                    if (div == '0) begin
                        wr.wr_en   <= 1'b1;
                        wr.wr_addr <= idx;
                        wr.wr_data <= scaled;
                        if (idx == idx_last) begin
                            wr.frame_done <= 1'b1;
                            state         <= HOLDOFF;
                            hold          <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    // A rise landing on the expiry cycle is dropped, not deferred
                    if (hold == hold_last)
                        state <= ARM;
                    else
                        hold <= hold + 1'b1;
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: doc/mic_trigger_capture.md
Name: mic_trigger_capture

Overview:
- Upstream stage of the oscilloscope display.
- Conditions the 24-bit microphone stream and detects rising zero-crossings with a Schmitt hysteresis, and measures the signal period in clocks.
- On a trigger, captures one frame of decimated, scaled, saturated samples and emits them as write strobes into the display's sample buffer.
- Gives a stable, trigger-aligned trace instead of free-running overwrites.

Parameters:
- w_y, 9: width of signed sample written to the buffer.
- n_samples, 320: samples per frame (buffer depth).
- w_addr, $clog2(n_samples): buffer address width.
- mic_shift, 9: arithmetic right shift applied to mic before saturation.
- hyst, 24'sd4096: Schmitt threshold magnitude; crossing levels are +hyst and -hyst.
- holdoff_cycles, 1024: idle clocks after a frame before re-arming.
- timeout_cycles, 2**20: auto-trigger timeout, used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mic  in  24  signed microphone sample, valid every clock
- decim_log2  in  4  decimation exponent; one sample taken every 2**decim_log2 clocks
- freeze  in  1  1 = do not leave ARM (hold last frame)
- wr_en  out  1  buffer write strobe
- wr_addr  out  w_addr  buffer write address
- wr_data  out  w_y  signed scaled sample
- frame_done  out  1  one-cycle pulse coincident with last wr_en of a frame
- period  out  20  clocks between the last two rising crossings
- period_valid  out  1  one-cycle pulse when period updates
- auto_trig  out  1  1 = current/last frame was auto-triggered

Behaviour:
- Reset:
  - Async, immediate.
  - State = ARM; Schmitt level = 0; all counters = 0.
  - wr_en, wr_addr, wr_data, frame_done, period, period_valid, auto_trig all = 0.
  - First-rise flag cleared.
- Schmitt detector (runs in every state):
  - level 0 -> 1 when signed mic > +hyst.
  - level 1 -> 0 when signed mic < -hyst.
  - Between the two thresholds, level holds.
  - rise: registered pulse, high the cycle after mic first exceeds +hyst with level 0.
- Period counter (20-bit):
  - Increments each clock, saturates at 20'hFFFFF.
  - On rise: period <= counter, counter <= 1, period_valid pulses.
  - A crossing at cycle t followed by one at t+P yields period = P.
  - The first rise after reset only restarts the counter: no period_valid, period unchanged.
- Scaling:
  - s = mic >>> mic_shift, saturated to [-(2**(w_y-1)), 2**(w_y-1)-1].
  - Defaults: clamp to [-256, 255].
- FSM:
  - ARM:
    - on rise && !freeze -> CAPTURE.
    - Entry actions: latch decim_log2, div = 0, idx = 0, auto_trig <= 0.
  - CAPTURE:
    - A tick occurs each cycle with div == 0.
    - div increments, wrapping at 2**d-1 (d = latched value).
    - On a tick, registered next cycle: wr_en = 1, wr_addr = idx, wr_data = scale(mic of tick cycle); idx++.
    - On the tick with idx == n_samples-1: the write carries frame_done = 1, then -> HOLDOFF.
    - freeze and decim_log2 changes are ignored during CAPTURE.
  - HOLDOFF:
    - Counts holdoff_cycles clocks after the final write, then -> ARM.
    - Rises during HOLDOFF still update period but do not trigger.
- Timing, d = 0: rise pulse at cycle T gives CAPTURE at T+1, ticks at T+1..T+n_samples, wr_en at T+2..T+n_samples+1.
- wr_en is never asserted outside a frame. Addresses are strictly 0..n_samples-1, ascending, with no gaps.
- Simultaneous rise and HOLDOFF expiry: no trigger; the rise is consumed.
- Reset mid-frame: wr_en drops immediately; the partial frame is abandoned.

Optional Feature:
- Macro: MIC_TRIGGER_CAPTURE_AUTO_EN.
- With the macro defined:
  - In ARM with !freeze, an idle counter counts clocks.
  - Reaching timeout_cycles without a rise forces entry to CAPTURE with auto_trig <= 1.
  - The idle counter clears on leaving ARM or on any rise.
- Without the macro: no idle counter; auto_trig is tied to 0; ARM waits indefinitely.

Test Plan:
- Reset check: assert rst mid-frame -> wr_en = 0, period = 0, frame_done = 0 within the same cycle; FSM in ARM after release.
- Square wave ±100000, half-period 500 clocks, decim_log2 = 0:
  - Second and later rises give period = 1000 with period_valid pulses.
  - The first rise after reset gives no pulse.
- Trigger and frame, same wave:
  - 320 writes on consecutive cycles, addresses 0..319.
  - wr_data = 195 for positive samples (100000 >>> 9), -196 for negative samples.
  - frame_done only at addr 319.
- Decimation: decim_log2 = 3 -> writes spaced exactly 8 clocks apart; changing decim_log2 mid-frame does not alter spacing.
- Saturation and hysteresis:
  - mic = +2000000 -> wr_data 255; mic = -2000000 -> -256.
  - A ±3000 sine produces no rise and no trigger.
- Freeze and auto:
  - freeze = 1 -> no writes despite rises.
  - With MIC_TRIGGER_CAPTURE_AUTO_EN, timeout_cycles = 64, constant mic = 0 -> capture starts 64 clocks into ARM with auto_trig = 1.
